// File: rtl/tdl_pkg.sv
// Shared helpers for the tapped delay line: width functions and the tap index type.
package tdl_pkg;

  localparam int unsigned MaxTw = 8;

  typedef logic [MaxTw-1:0] tap_idx_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r = 0;
    int unsigned x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  // Index width for TAPS taps; never zero so a single-tap line still has a port.
  function automatic int unsigned tw_of(input int unsigned taps);
    return (clog2(taps) == 0) ? 1 : clog2(taps);
  endfunction

  function automatic int unsigned depth_of(input int unsigned taps, input int unsigned spacing);
    return taps * spacing;
  endfunction

  // Counter must reach MIN_PW-1.
  function automatic int unsigned cnt_w_of(input int unsigned min_pw);
    return (clog2(min_pw) == 0) ? 1 : clog2(min_pw);
  endfunction

endpackage

// File: rtl/tapped_delay_line_sync_if.sv
// Bus bundle between the delay line and its user: enable, inputs, window select, taps.
interface tapped_delay_line_sync_if #(
  parameter int unsigned CHANNELS = 1,
  parameter int unsigned TAPS     = 5
) ();

  localparam int unsigned TW = tdl_pkg::tw_of(TAPS);

  logic                     en;
  logic [CHANNELS-1:0]      din;
  logic [CHANNELS*TAPS-1:0] tap_o;
  logic [TW-1:0]            win_start;
  logic [TW-1:0]            win_end;
  logic [CHANNELS-1:0]      win_o;

  modport master (
    output en, din, win_start, win_end,
    input  tap_o, win_o
  );

  modport slave (
    input  en, din, win_start, win_end,
    output tap_o, win_o
  );

endinterface

// File: rtl/tdl_channel.sv
// One delay line: optional min-width deglitch filter feeding a DEPTH-stage shift register.
module tdl_channel import tdl_pkg::*; #(
  parameter int unsigned TAPS        = 5,
  parameter int unsigned TAP_SPACING = 1,
  parameter int unsigned MIN_PW      = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            din_i,
  output logic [TAPS-1:0] tap_o
);

  localparam int unsigned Depth = depth_of(TAPS, TAP_SPACING);
  localparam int unsigned CntW  = cnt_w_of(MIN_PW);
  localparam logic [CntW-1:0] CntLast = CntW'(MIN_PW - 1);

  logic [Depth-1:0] stage_q, stage_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  always_comb begin
    stage_d = stage_q;
    cnt_d   = '0;
    // Load only on the MIN_PW-th consecutive differing sample; any agreement clears the count.
    if (din_i != stage_q[0]) begin
      if (cnt_q == CntLast) begin
        stage_d[0] = din_i;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    for (int unsigned i = 1; i < Depth; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else if (en_i) begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    assign tap_o[k] = stage_q[(k+1)*TAP_SPACING-1];
  end

endmodule

// File: rtl/tapped_delay_line_sync.sv
// Multi-channel clocked tapped delay line with a shared runtime-selected tap window.
module tapped_delay_line_sync import tdl_pkg::*; #(
  parameter int unsigned CHANNELS    = 1,
  parameter int unsigned TAPS        = 5,
  parameter int unsigned TAP_SPACING = 1,
  parameter int unsigned MIN_PW      = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  tapped_delay_line_sync_if.slave bus
);

  tap_idx_t start_idx, end_idx;
  logic     win_valid;

  assign start_idx = tap_idx_t'(bus.win_start);
  assign end_idx   = tap_idx_t'(bus.win_end);
  // Out-of-range or empty/reversed selections disable the window entirely.
  assign win_valid = (start_idx < end_idx) && (end_idx < tap_idx_t'(TAPS));

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [TAPS-1:0] taps;
    logic            sel_start, sel_end;

    tdl_channel #(
      .TAPS        (TAPS),
      .TAP_SPACING (TAP_SPACING),
      .MIN_PW      (MIN_PW)
    ) u_ch (
      .clk_i (clk),
      .rst_i (reset),
      .en_i  (bus.en),
      .din_i (bus.din[c]),
      .tap_o (taps)
    );

    assign bus.tap_o[c*TAPS +: TAPS] = taps;

    always_comb begin
      sel_start = 1'b0;
      sel_end   = 1'b0;
      for (int unsigned k = 0; k < TAPS; k++) begin
        if (tap_idx_t'(k) == start_idx) sel_start = taps[k];
        if (tap_idx_t'(k) == end_idx)   sel_end   = taps[k];
      end
    end

    assign bus.win_o[c] = win_valid & sel_start & ~sel_end;
  end

endmodule

// File: tb/tb_tapped_delay_line_sync.sv
// Directed bench: three parameterisations of the delay line driven from one linear sequence.
module tb_tapped_delay_line_sync;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // a: defaults with two channels; b: 4 taps spaced 3; c: min pulse width 4.
  tapped_delay_line_sync_if #(.CHANNELS(2), .TAPS(5)) if_a ();
  tapped_delay_line_sync_if #(.CHANNELS(1), .TAPS(4)) if_b ();
  tapped_delay_line_sync_if #(.CHANNELS(1), .TAPS(5)) if_c ();

  tapped_delay_line_sync #(.CHANNELS(2), .TAPS(5), .TAP_SPACING(1), .MIN_PW(1)) u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a)
  );

  tapped_delay_line_sync #(.CHANNELS(1), .TAPS(4), .TAP_SPACING(3), .MIN_PW(1)) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b)
  );

  tapped_delay_line_sync #(.CHANNELS(1), .TAPS(5), .TAP_SPACING(1), .MIN_PW(4)) u_c (
    .clk   (clk),
    .reset (reset),
    .bus   (if_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Input high in cycles [s, s+w-1] shows on tap k in cycles [s+(k+1)*sp, s+w-1+(k+1)*sp].
  function automatic logic [31:0] exp_taps(input int c, input int s, input int w,
                                           input int taps, input int sp, input int off);
    logic [31:0] r = '0;
    for (int k = 0; k < taps; k++) begin
      if (c >= s + (k+1)*sp && c <= s + w - 1 + (k+1)*sp) r[off+k] = 1'b1;
    end
    return r;
  endfunction

  task automatic flush_a(input int n);
    if_a.din = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int e;
    reset = 1'b1;
    if_a.en = 1'b1; if_a.din = '0; if_a.win_start = '0; if_a.win_end = '0;
    if_b.en = 1'b1; if_b.din = '0; if_b.win_start = '0; if_b.win_end = '0;
    if_c.en = 1'b1; if_c.din = '0; if_c.win_start = '0; if_c.win_end = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_tap_a", if_a.tap_o, 32'h0);
    chk("rst_win_a", if_a.win_o, 32'h0);
    chk("rst_tap_b", if_b.tap_o, 32'h0);
    chk("rst_tap_c", if_c.tap_o, 32'h0);

    // Test 1: single-clock pulse in cycle 10 walks the five taps, no window.
    for (int c = 0; c <= 18; c++) begin
      chk("t1_tap", if_a.tap_o, exp_taps(c, 10, 1, 5, 1, 0));
      chk("t1_win", if_a.win_o, 32'h0);
      if_a.din = (c == 10) ? 2'b01 : 2'b00;
      tick();
    end

    // Test 2: step into 4 taps spaced 3; window between taps 1 and 3 lasts 6 clocks.
    if_b.win_start = 2'd1;
    if_b.win_end   = 2'd3;
    for (int c = 0; c <= 15; c++) begin
      chk("t2_tap", if_b.tap_o, exp_taps(c, 0, 1000, 4, 3, 0));
      chk("t2_win", if_b.win_o, (c >= 6 && c <= 11) ? 32'h1 : 32'h0);
      if_b.din = 1'b1;
      tick();
    end
    if_b.din = 1'b0;

    // Test 3: 3-clock pulse is filtered out, 4-clock pulse passes delayed by 3.
    for (int c = 0; c <= 10; c++) begin
      chk("t3_short", if_c.tap_o, 32'h0);
      if_c.din = (c < 3);
      tick();
    end
    for (int c = 0; c <= 14; c++) begin
      chk("t3_long", if_c.tap_o, exp_taps(c, 3, 4, 5, 1, 0));
      if_c.din = (c < 4);
      tick();
    end

    // Test 4: en low in cycles 5..7 freezes the line; timeline slips by 3.
    for (int c = 0; c <= 14; c++) begin
      e = (c <= 5) ? c : ((c <= 8) ? 5 : c - 3);
      chk("t4_tap", if_a.tap_o, exp_taps(e, 0, 2, 5, 1, 0));
      if_a.din = (c <= 1) ? 2'b01 : 2'b00;
      if_a.en  = !(c >= 5 && c <= 7);
      tick();
    end
    if_a.en = 1'b1;
    flush_a(8);

    // Test 5: reset (with en low, reset still wins) while ones are in flight.
    if_a.win_start = 3'd0;
    if_a.win_end   = 3'd4;
    if_a.din = 2'b11;
    tick();
    tick();
    chk("t5_pre_tap", if_a.tap_o, 32'h063);
    chk("t5_pre_win", if_a.win_o, 32'h3);
    if_a.en = 1'b0;
    reset = 1'b1;
    if_a.din = 2'b00;
    tick();
    chk("t5_rst_tap", if_a.tap_o, 32'h0);
    chk("t5_rst_win", if_a.win_o, 32'h0);
    reset = 1'b0;
    if_a.en = 1'b1;
    if_a.din = 2'b10;
    tick();
    chk("t5_new_tap0", if_a.tap_o, 32'h020);
    chk("t5_new_win", if_a.win_o, 32'h2);
    if_a.din = 2'b00;
    tick();
    tick();
    chk("t5_new_tap2", if_a.tap_o, 32'h080);
    chk("t5_end_win", if_a.win_o, 32'h0);
    flush_a(8);

    // Test 6: distinct stimuli per channel, reversed window selection.
    if_a.win_start = 3'd3;
    if_a.win_end   = 3'd1;
    for (int c = 0; c <= 11; c++) begin
      chk("t6_tap", if_a.tap_o, exp_taps(c, 0, 1, 5, 1, 0) | exp_taps(c, 2, 2, 5, 1, 5));
      chk("t6_win", if_a.win_o, 32'h0);
      if_a.din = {(c >= 2 && c <= 3), (c == 0)};
      tick();
    end

    // Out-of-range end index disables the window; a legal one enables it.
    if_a.win_start = 3'd0;
    if_a.win_end   = 3'd6;
    if_a.din = 2'b01;
    tick();
    if_a.din = 2'b00;
    chk("t7_tap", if_a.tap_o, 32'h001);
    chk("t7_win_oor", if_a.win_o, 32'h0);
    if_a.win_end = 3'd4;
    #1;
    chk("t7_win_ok", if_a.win_o, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
